// File: rtl/pixel_pkg.sv
// Shared types and defaults for the pixel frame reader.
package pixel_pkg;

    localparam int unsigned PIX_DATA_W = 8;
    localparam int unsigned PIX_N_PIX  = 4;
    localparam int unsigned PIX_IDX_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READ    = 3'd4
    } phase_e;

    typedef struct packed {
        logic [PIX_IDX_W-1:0]  idx;
        logic [PIX_DATA_W-1:0] data;
    } pix_word_t;

    // Bit position of a one-hot read vector (lowest set bit wins).
    function automatic logic [PIX_IDX_W-1:0] onehot_to_idx(input logic [PIX_N_PIX-1:0] oh);
        logic [PIX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = PIX_N_PIX - 1; i >= 0; i--) begin
            if (oh[i]) idx = PIX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pixel_sync_fifo.sv
// First-word fall-through FIFO of pixel words; a pop frees a slot for a same-cycle push.
module pixel_sync_fifo
    import pixel_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  pix_word_t wdata_i,
    input  logic      pop_i,
    output pix_word_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    pix_word_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array; no reset needed, occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pixel_frame_reader.sv
// Checks the erase/expose/convert/read phase sequence, captures ADC codes on
// read rising edges and streams them out through a small FIFO.
// DATA_W and N_PIX must match the pixel_pkg defaults in this release.
module pixel_frame_reader
    import pixel_pkg::*;
#(
    parameter int unsigned DATA_W     = PIX_DATA_W,
    parameter int unsigned N_PIX      = PIX_N_PIX,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              erase,
    input  logic              expose,
    input  logic              convert,
    input  logic [N_PIX-1:0]  read,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              seq_err,
    output logic              overflow,
    output logic [CNT_W-1:0]  frame_cnt
);

    phase_e             state_q, state_d;
    logic [N_PIX-1:0]   read_prev_q;
    logic [N_PIX-1:0]   lane_mask_q, lane_mask_d;
    logic               frame_done_q, frame_done_d;
    logic               seq_err_q, seq_err_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic               any_read;
    logic [N_PIX-1:0]   rise;
    logic               read_multi;
    logic [2:0]         n_strb;
    logic               phase_multi;
    logic               bad_strb;
    logic               cap_try;
    logic               dup;
    logic               push;
    logic               complete;

    pix_word_t          wdata;
    pix_word_t          head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    // Strobe decode: edge detect, multi-hot checks and per-phase legality.
    always_comb begin
        any_read    = |read;
        rise        = read & ~read_prev_q;
        read_multi  = (read & (read - N_PIX'(1))) != '0;
        n_strb      = 3'(erase) + 3'(expose) + 3'(convert) + 3'(any_read);
        phase_multi = n_strb > 3'd1;
        bad_strb    = 1'b0;
        case (state_q)
            S_IDLE:    bad_strb = expose || convert || (|rise);
            S_ERASE:   bad_strb = convert || any_read;
            S_EXPOSE:  bad_strb = erase || any_read;
            S_CONVERT: bad_strb = erase || expose;
            S_READ:    bad_strb = expose || convert;
            default:   bad_strb = 1'b1;
        endcase
        cap_try  = ((state_q == S_CONVERT) || (state_q == S_READ)) && !phase_multi &&
                   !bad_strb && !read_multi && (|rise);
        dup      = cap_try && ((lane_mask_q & rise) != '0);
        push     = cap_try && !dup;
        complete = push && (&(lane_mask_q | rise));
    end

    // Next phase.
    always_comb begin
        state_d = state_q;
        if (phase_multi || bad_strb) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (erase)    state_d = S_ERASE;
                S_ERASE:   if (expose)   state_d = S_EXPOSE;
                S_EXPOSE:  if (convert)  state_d = S_CONVERT;
                S_CONVERT: if (any_read) state_d = complete ? S_IDLE : S_READ;
                S_READ: begin
                    if (erase)         state_d = S_ERASE;
                    else if (complete) state_d = S_IDLE;
                end
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Flag, counter and lane-mask updates.
    always_comb begin
        frame_done_d = complete;
        frame_cnt_d  = complete ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
        seq_err_d    = seq_err_q | phase_multi | bad_strb | read_multi | dup |
                       ((state_q == S_READ) && erase);
        overflow_d   = overflow_q | (push && fifo_full && !pop);
        lane_mask_d  = '0;
        if ((state_d == S_CONVERT) || (state_d == S_READ)) begin
            lane_mask_d = push ? (lane_mask_q | rise) : lane_mask_q;
        end
        wdata.idx  = onehot_to_idx(PIX_N_PIX'(read));
        wdata.data = PIX_DATA_W'(adc_data);
    end

    // Phase state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Edge history, lane mask, flags and frame counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_prev_q  <= '0;
            lane_mask_q  <= '0;
            frame_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
            overflow_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            read_prev_q  <= read;
            lane_mask_q  <= lane_mask_d;
            frame_done_q <= frame_done_d;
            seq_err_q    <= seq_err_d;
            overflow_q   <= overflow_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign pop = out_valid && out_ready;

    pixel_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = DATA_W'(head.data);
    assign out_idx    = head.idx;
    assign frame_done = frame_done_q;
    assign seq_err    = seq_err_q;
    assign overflow   = overflow_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pixel_frame_reader.sv
// Directed bench: a default instance, a 2-deep FIFO instance and a 2-bit
// counter instance share the same stimulus.
module tb_pixel_frame_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        erase, expose, convert;
    logic [3:0]  read;
    logic [7:0]  adc;
    logic        out_ready;

    logic [7:0]  data_a, data_b, data_c;
    logic [1:0]  idx_a, idx_b, idx_c;
    logic        valid_a, valid_b, valid_c;
    logic        done_a, done_b, done_c;
    logic        err_a, err_b, err_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt_a = 0;
    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    always #5 clk = ~clk;

    pixel_frame_reader #(.FIFO_DEPTH(4), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_n), .erase(erase), .expose(expose), .convert(convert),
        .read(read), .adc_data(adc), .out_data(data_a), .out_idx(idx_a), .out_valid(valid_a),
        .out_ready(out_ready), .frame_done(done_a), .seq_err(err_a), .overflow(ovf_a),
        .frame_cnt(cnt_a));

    pixel_frame_reader #(.FIFO_DEPTH(2), .CNT_W(16)) dut_b (
        .clk(clk), .reset(rst_n), .erase(erase), .expose(expose), .convert(convert),
        .read(read), .adc_data(adc), .out_data(data_b), .out_idx(idx_b), .out_valid(valid_b),
        .out_ready(out_ready), .frame_done(done_b), .seq_err(err_b), .overflow(ovf_b),
        .frame_cnt(cnt_b));

    pixel_frame_reader #(.FIFO_DEPTH(4), .CNT_W(2)) dut_c (
        .clk(clk), .reset(rst_n), .erase(erase), .expose(expose), .convert(convert),
        .read(read), .adc_data(adc), .out_data(data_c), .out_idx(idx_c), .out_valid(valid_c),
        .out_ready(out_ready), .frame_done(done_c), .seq_err(err_c), .overflow(ovf_c),
        .frame_cnt(cnt_c));

    // Record every accepted word; the pop happens at the following rising edge.
    always @(negedge clk) begin
        if (valid_a && out_ready) q_a.push_back({idx_a, data_a});
        if (valid_b && out_ready) q_b.push_back({idx_b, data_b});
        if (done_a) done_cnt_a++;
    end

    typedef struct {
        logic       e, x, c;
        logic [3:0] rd;
        logic [7:0] adc;
        int         n;
        logic       v;
        logic [7:0] d;
        logic [1:0] i;
        logic       done, err;
        logic [15:0] cnt;
    } step_t;

    step_t steps[$];

    function automatic step_t mk(logic e, logic x, logic c, logic [3:0] rd, logic [7:0] a, int n,
                                 logic v, logic [7:0] d, logic [1:0] i, logic done, logic err,
                                 logic [15:0] cnt);
        step_t s;
        s.e = e; s.x = x; s.c = c; s.rd = rd; s.adc = a; s.n = n;
        s.v = v; s.d = d; s.i = i; s.done = done; s.err = err; s.cnt = cnt;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic x, input logic c, input logic [3:0] rd,
                         input logic [7:0] a, input int n);
        erase = e; expose = x; convert = c; read = rd; adc = a;
        repeat (n) tick();
    endtask

    task automatic run_frame(input logic [7:0] base);
        drive(1, 0, 0, 4'b0000, 8'h00, 1);
        drive(0, 1, 0, 4'b0000, 8'h00, 1);
        drive(0, 0, 1, 4'b0000, 8'h00, 1);
        for (int l = 0; l < 4; l++) drive(0, 0, 0, 4'(1 << l), base + 8'(l + 1), 1);
        drive(0, 0, 0, 4'b0000, 8'h00, 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 4'b0000, 8'h00, 2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_q(input string name, input logic [9:0] q[$], input logic [9:0] exp[$]);
        check({name, "_len"}, 32'(q.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < q.size(); k++)
            check($sformatf("%s_%0d", name, k), 32'(q[k]), 32'(exp[k]));
    endtask

    initial begin
        logic [9:0] exp_q[$];

        // legal frame, then an order violation followed by a recovering frame
        steps.push_back(mk(0,0,0,4'h0,8'h00,  2, 0,8'h00,0, 0,0,0));
        steps.push_back(mk(1,0,0,4'h0,8'h00,  5, 0,8'h00,0, 0,0,0));
        steps.push_back(mk(0,1,0,4'h0,8'h00,255, 0,8'h00,0, 0,0,0));
        steps.push_back(mk(0,0,1,4'h0,8'h00,255, 0,8'h00,0, 0,0,0));
        steps.push_back(mk(0,0,0,4'h1,8'h11,  1, 1,8'h11,0, 0,0,0));
        steps.push_back(mk(0,0,0,4'h1,8'h11,  4, 0,8'h00,0, 0,0,0));
        steps.push_back(mk(0,0,0,4'h2,8'h22,  1, 1,8'h22,1, 0,0,0));
        steps.push_back(mk(0,0,0,4'h2,8'h22,  4, 0,8'h00,0, 0,0,0));
        steps.push_back(mk(0,0,0,4'h4,8'h33,  1, 1,8'h33,2, 0,0,0));
        steps.push_back(mk(0,0,0,4'h4,8'h33,  4, 0,8'h00,0, 0,0,0));
        steps.push_back(mk(0,0,0,4'h8,8'h44,  1, 1,8'h44,3, 1,0,1));
        steps.push_back(mk(0,0,0,4'h8,8'h44,  4, 0,8'h00,0, 0,0,1));
        steps.push_back(mk(0,0,0,4'h0,8'h00,  2, 0,8'h00,0, 0,0,1));
        steps.push_back(mk(0,1,0,4'h0,8'h00,  1, 0,8'h00,0, 0,1,1));
        steps.push_back(mk(0,0,0,4'h0,8'h00,  1, 0,8'h00,0, 0,1,1));
        steps.push_back(mk(1,0,0,4'h0,8'h00,  1, 0,8'h00,0, 0,1,1));
        steps.push_back(mk(0,1,0,4'h0,8'h00,  1, 0,8'h00,0, 0,1,1));
        steps.push_back(mk(0,0,1,4'h0,8'h00,  1, 0,8'h00,0, 0,1,1));
        steps.push_back(mk(0,0,0,4'h1,8'h55,  1, 1,8'h55,0, 0,1,1));
        steps.push_back(mk(0,0,0,4'h2,8'h66,  1, 1,8'h66,1, 0,1,1));
        steps.push_back(mk(0,0,0,4'h4,8'h77,  1, 1,8'h77,2, 0,1,1));
        steps.push_back(mk(0,0,0,4'h8,8'h88,  1, 1,8'h88,3, 1,1,2));
        steps.push_back(mk(0,0,0,4'h0,8'h00,  2, 0,8'h00,0, 0,1,2));

        rst_n = 1'b0; out_ready = 1'b1;
        erase = 0; expose = 0; convert = 0; read = '0; adc = '0;
        repeat (3) tick();
        rst_n = 1'b1;

        for (int k = 0; k < steps.size(); k++) begin
            step_t s;
            s = steps[k];
            drive(s.e, s.x, s.c, s.rd, s.adc, s.n);
            check($sformatf("row%0d_valid", k), 32'(valid_a), 32'(s.v));
            if (s.v) begin
                check($sformatf("row%0d_data", k), 32'(data_a), 32'(s.d));
                check($sformatf("row%0d_idx", k), 32'(idx_a), 32'(s.i));
            end
            check($sformatf("row%0d_done", k), 32'(done_a), 32'(s.done));
            check($sformatf("row%0d_err", k), 32'(err_a), 32'(s.err));
            check($sformatf("row%0d_cnt", k), 32'(cnt_a), 32'(s.cnt));
            check($sformatf("row%0d_ovf", k), 32'(ovf_a), 32'(0));
        end
        check("table_cnt_c", 32'(cnt_c), 32'(2));

        // async reset mid-read after two captures
        out_ready = 1'b0;
        drive(1, 0, 0, 4'h0, 8'h00, 1);
        drive(0, 1, 0, 4'h0, 8'h00, 1);
        drive(0, 0, 1, 4'h0, 8'h00, 1);
        drive(0, 0, 0, 4'h1, 8'hA1, 1);
        drive(0, 0, 0, 4'h2, 8'hA2, 1);
        read = '0;
        check("pre_rst_valid", 32'(valid_a), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(valid_a), 32'(0));
        check("rst_cnt", 32'(cnt_a), 32'(0));
        check("rst_err", 32'(err_a), 32'(0));
        check("rst_cnt_c", 32'(cnt_c), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        q_a.delete(); q_b.delete(); done_cnt_a = 0;
        out_ready = 1'b1;
        run_frame(8'hA0);
        drive(0, 0, 0, 4'h0, 8'h00, 2);
        exp_q = '{10'h0A1, 10'h1A2, 10'h2A3, 10'h3A4};
        check_q("rst_frame", q_a, exp_q);
        check("rst_frame_done", 32'(done_cnt_a), 32'(1));
        check("rst_frame_cnt", 32'(cnt_a), 32'(1));
        check("rst_frame_err", 32'(err_a), 32'(0));

        // multi-hot read and duplicate lane
        q_a.delete();
        drive(1, 0, 0, 4'h0, 8'h00, 1);
        drive(0, 1, 0, 4'h0, 8'h00, 1);
        drive(0, 0, 1, 4'h0, 8'h00, 1);
        drive(0, 0, 0, 4'h1, 8'hB1, 1);
        check("mh_err_before", 32'(err_a), 32'(0));
        drive(0, 0, 0, 4'h0, 8'h00, 1);
        drive(0, 0, 0, 4'h3, 8'hBB, 1);
        check("mh_err", 32'(err_a), 32'(1));
        check("mh_no_push", 32'(valid_a), 32'(0));
        drive(0, 0, 0, 4'h0, 8'h00, 1);
        drive(0, 0, 0, 4'h4, 8'hB3, 1);
        check("dup_first_valid", 32'(valid_a), 32'(1));
        check("dup_first_data", 32'(data_a), 32'(8'hB3));
        drive(0, 0, 0, 4'h0, 8'h00, 1);
        drive(0, 0, 0, 4'h4, 8'hEE, 1);
        check("dup_no_push", 32'(valid_a), 32'(0));
        drive(0, 0, 0, 4'h2, 8'hB2, 1);
        drive(0, 0, 0, 4'h8, 8'hB4, 1);
        check("dup_frame_done", 32'(done_a), 32'(1));
        check("dup_frame_cnt", 32'(cnt_a), 32'(2));
        drive(0, 0, 0, 4'h0, 8'h00, 2);
        exp_q = '{10'h0B1, 10'h2B3, 10'h1B2, 10'h3B4};
        check_q("dup_frame", q_a, exp_q);

        // backpressure: hold the stream until after the last read
        q_a.delete(); q_b.delete();
        out_ready = 1'b0;
        drive(1, 0, 0, 4'h0, 8'h00, 5);
        drive(0, 1, 0, 4'h0, 8'h00, 5);
        drive(0, 0, 1, 4'h0, 8'h00, 5);
        drive(0, 0, 0, 4'h1, 8'h11, 1);
        check("bp_first_valid", 32'(valid_a), 32'(1));
        check("bp_first_head", 32'({idx_a, data_a}), 32'(10'h011));
        drive(0, 0, 0, 4'h1, 8'h11, 4);
        drive(0, 0, 0, 4'h2, 8'h22, 5);
        drive(0, 0, 0, 4'h4, 8'h33, 5);
        drive(0, 0, 0, 4'h8, 8'h44, 5);
        drive(0, 0, 0, 4'h0, 8'h00, 1);
        check("bp_hold_valid", 32'(valid_a), 32'(1));
        check("bp_hold_head", 32'({idx_a, data_a}), 32'(10'h011));
        check("bp_ovf_a", 32'(ovf_a), 32'(0));
        check("bp_cnt_a", 32'(cnt_a), 32'(3));
        check("bp_ovf_b", 32'(ovf_b), 32'(1));
        check("bp_head_b", 32'({idx_b, data_b}), 32'(10'h011));
        out_ready = 1'b1;
        drive(0, 0, 0, 4'h0, 8'h00, 6);
        exp_q = '{10'h011, 10'h122, 10'h233, 10'h344};
        check_q("bp_drain_a", q_a, exp_q);
        exp_q = '{10'h011, 10'h122};
        check_q("bp_drain_b", q_b, exp_q);
        check("bp_empty_a", 32'(valid_a), 32'(0));

        // frame counter wrap on the 2-bit instance
        pulse_reset();
        for (int f = 0; f < 5; f++) begin
            run_frame(8'hC0);
            check($sformatf("wrap_cnt_c_%0d", f), 32'(cnt_c), 32'((f + 1) % 4));
            check($sformatf("wrap_cnt_a_%0d", f), 32'(cnt_a), 32'(f + 1));
        end
        check("wrap_err_c", 32'(err_c), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
